// File: rtl/up_dn_counter_sched.sv
// Two-requester scheduler driving an up/down counter's Load/Up/Down controls.
// Define SCHED_FAIR_EN for round-robin arbitration; default is fixed priority.
module up_dn_counter_sched (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] op0,
    input  logic [1:0] op1,
    input  logic [4:0] val0,
    input  logic [4:0] val1,
    output logic [1:0] ack,
    output logic       sat,
    output logic       busy,
    output logic       gnt_id,
    output logic [4:0] cnt_in,
    output logic       cnt_load,
    output logic       cnt_up,
    output logic       cnt_down,
    input  logic       cnt_high,
    input  logic       cnt_low
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DN   = 2'b11;

    state_t     state;
    logic [4:0] remaining;
    logic       up_en;
    logic       dn_en;
    logic       win;
    logic [1:0] op_w;
    logic [4:0] val_w;
    logic       lim;
    logic       stepping;

`ifdef SCHED_FAIR_EN
    logic ptr;

    always_comb begin
        win = ptr;
        if (req == 2'b01)
            win = 1'b0;
        else if (req == 2'b10)
            win = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (state == IDLE && |req)
            ptr <= ~win;
    end
`else
    assign win = ~req[0];
`endif

    assign op_w  = win ? op1 : op0;
    assign val_w = win ? val1 : val0;
    assign lim   = up_en ? cnt_high : cnt_low;

    // Step enables are flops; the limit flag masks them so no step
    // ever lands on a counter already sitting at its limit.
    assign stepping = (up_en | dn_en) & (remaining != 5'd0);
    assign cnt_up   = up_en & (remaining != 5'd0) & ~cnt_high;
    assign cnt_down = dn_en & (remaining != 5'd0) & ~cnt_low;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ack       <= 2'b00;
            sat       <= 1'b0;
            busy      <= 1'b0;
            gnt_id    <= 1'b0;
            cnt_in    <= 5'd0;
            cnt_load  <= 1'b0;
            up_en     <= 1'b0;
            dn_en     <= 1'b0;
            remaining <= 5'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= EXEC;
                        busy      <= 1'b1;
                        gnt_id    <= win;
                        remaining <= val_w;
                        cnt_load  <= (op_w == OP_LOAD);
                        cnt_in    <= (op_w == OP_LOAD) ? val_w : 5'd0;
                        up_en     <= (op_w == OP_UP);
                        dn_en     <= (op_w == OP_DN);
                    end
                end
                EXEC: begin
                    cnt_load <= 1'b0;
                    cnt_in   <= 5'd0;
                    if (stepping && !lim) begin
                        remaining <= remaining - 5'd1;
                    end else begin
                        state     <= ACK;
                        sat       <= stepping;
                        ack       <= gnt_id ? 2'b10 : 2'b01;
                        up_en     <= 1'b0;
                        dn_en     <= 1'b0;
                        remaining <= 5'd0;
                    end
                end
                ACK: begin
                    if (!req[gnt_id]) begin
                        state <= IDLE;
                        ack   <= 2'b00;
                        sat   <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
